sdram_init_refresh_ctrl: RTL and testbench

Sequencer owning SDRAM power-up initialisation and periodic auto-refresh scheduling for the SDRAM controller behind the Wishbone slave. After reset it drives the JEDEC init sequence: power-up NOP wait, PRECHARGE-ALL, N AUTO-REFRESH, MODE REGISTER SET. It then counts refresh intervals, accumulates pending refreshes and borrows the SDRAM command bus from the access FSM through a req/gnt handshake. Its command outputs are muxed onto the SDRAM pins by the top level whenever cmd_own=1.

---
 rtl/sdram_init_refresh_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_sdram_init_refresh_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sdram_init_refresh_ctrl.sv
// SDRAM power-up initialisation and periodic auto-refresh sequencer.
// Command outputs are registered and decoded from the next state, so a
// command appears on the edge its state is entered and lasts one cycle.
//
// state  | meaning
// -------+-----------------------------------------------------------
// PWRUP  | power-up NOP wait after reset release
// I_PRE  | init PRECHARGE-ALL issued
// I_TRP  | init precharge recovery wait
// I_AR   | init AUTO-REFRESH issued
// I_TRFC | init refresh recovery wait
// I_MRS  | MODE REGISTER SET issued
// I_TMRD | mode register recovery wait
// IDLE   | command bus released to the access FSM
// R_PRE  | refresh PRECHARGE-ALL issued
// R_TRP  | refresh precharge recovery wait
// R_AR   | periodic AUTO-REFRESH issued
// R_TRFC | periodic refresh recovery wait
module sdram_init_refresh_ctrl #(
    parameter int                ADDR_W       = 13,
    parameter int                PWRUP_CYC    = 10000,
    parameter int                TRP          = 2,
    parameter int                TRFC         = 7,
    parameter int                TMRD         = 2,
    parameter int                INIT_AR      = 2,
    parameter int                REF_INTERVAL = 780,
    parameter int                URGENT_TH    = 6,
    parameter logic [ADDR_W-1:0] MODE_REG     = ADDR_W'(13'h033)
) (
    input  logic              sdram_clk,
    input  logic              sdram_rst,
    input  logic              ref_gnt,
    output logic              init_done,
    output logic              ref_req,
    output logic              ref_urgent,
    output logic [3:0]        ref_pend,
    output logic              cmd_own,
    output logic              cmd_cs_n,
    output logic              cmd_ras_n,
    output logic              cmd_cas_n,
    output logic              cmd_we_n,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [1:0]        cmd_ba
);

    localparam int T_MAX_A = (PWRUP_CYC > TRP) ? PWRUP_CYC : TRP;
    localparam int T_MAX_B = (TRFC > TMRD) ? TRFC : TMRD;
    localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
    localparam int CNT_W   = $clog2(T_MAX + 1);
    localparam int AR_W    = $clog2(INIT_AR + 1);
    localparam int TMR_W   = $clog2(REF_INTERVAL);

    localparam logic [3:0] CMD_INH = 4'b1111;
    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_AR  = 4'b0001;
    localparam logic [3:0] CMD_MRS = 4'b0000;

    // A10 high selects all banks for PRECHARGE
    localparam logic [ADDR_W-1:0] PRE_ADDR = ADDR_W'(1) << 10;

    typedef enum logic [3:0] {
        PWRUP, I_PRE, I_TRP, I_AR, I_TRFC, I_MRS, I_TMRD,
        IDLE, R_PRE, R_TRP, R_AR, R_TRFC
    } state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [AR_W-1:0]   ar_left, ar_left_nx;
    logic [TMR_W-1:0]  tmr;
    logic              done_nx;
    logic              tick;
    logic [3:0]        pend_nx;
    logic [3:0]        cmd_q, cmd_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic              own_nx;

    assign {cmd_cs_n, cmd_ras_n, cmd_cas_n, cmd_we_n} = cmd_q;
    assign cmd_ba = 2'b00;
    assign tick   = init_done && (tmr == '0);

    // Next-state, wait counters and registered output decode
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        ar_left_nx = ar_left;
        done_nx    = init_done;
        case (state)
            PWRUP: begin
                if (cnt == CNT_W'(PWRUP_CYC)) begin
                    state_nx   = I_PRE;
                    cnt_nx     = CNT_W'(TRP - 1);
                    ar_left_nx = AR_W'(INIT_AR);
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            I_PRE, I_TRP: begin
                if (cnt == '0) begin
                    state_nx   = I_AR;
                    cnt_nx     = CNT_W'(TRFC - 1);
                    ar_left_nx = ar_left - 1'b1;
                end else begin
                    state_nx = I_TRP;
                    cnt_nx   = cnt - 1'b1;
                end
            end
            I_AR, I_TRFC: begin
                if (cnt != '0) begin
                    state_nx = I_TRFC;
                    cnt_nx   = cnt - 1'b1;
                end else if (ar_left == '0) begin
                    state_nx = I_MRS;
                    cnt_nx   = CNT_W'(TMRD - 1);
                end else begin
                    state_nx   = I_AR;
                    cnt_nx     = CNT_W'(TRFC - 1);
                    ar_left_nx = ar_left - 1'b1;
                end
            end
            I_MRS, I_TMRD: begin
                if (cnt == '0) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end else begin
                    state_nx = I_TMRD;
                    cnt_nx   = cnt - 1'b1;
                end
            end
            IDLE: begin
                if (ref_req && ref_gnt) begin
                    state_nx = R_PRE;
                    cnt_nx   = CNT_W'(TRP - 1);
                end
            end
            R_PRE, R_TRP: begin
                if (cnt == '0) begin
                    state_nx = R_AR;
                    cnt_nx   = CNT_W'(TRFC - 1);
                end else begin
                    state_nx = R_TRP;
                    cnt_nx   = cnt - 1'b1;
                end
            end
            R_AR, R_TRFC: begin
                if (cnt == '0) begin
                    state_nx = IDLE;
                end else begin
                    state_nx = R_TRFC;
                    cnt_nx   = cnt - 1'b1;
                end
            end
            default: state_nx = PWRUP;
        endcase

        // A tick coinciding with a refresh cancels out
        pend_nx = ref_pend;
        if (tick && (state_nx != R_AR)) begin
            if (ref_pend != 4'd8) pend_nx = ref_pend + 1'b1;
        end else if (!tick && (state_nx == R_AR)) begin
            pend_nx = ref_pend - 1'b1;
        end

        cmd_nx  = CMD_NOP;
        addr_nx = '0;
        own_nx  = 1'b1;
        case (state_nx)
            I_PRE, R_PRE: begin
                cmd_nx  = CMD_PRE;
                addr_nx = PRE_ADDR;
            end
            I_AR, R_AR: cmd_nx = CMD_AR;
            I_MRS: begin
                cmd_nx  = CMD_MRS;
                addr_nx = MODE_REG;
            end
            IDLE:    own_nx = 1'b0;
            default: ;
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst) begin
            state      <= PWRUP;
            cnt        <= '0;
            ar_left    <= '0;
            tmr        <= '0;
            init_done  <= 1'b0;
            ref_pend   <= 4'd0;
            ref_req    <= 1'b0;
            ref_urgent <= 1'b0;
            cmd_own    <= 1'b1;
            cmd_q      <= CMD_INH;
            cmd_addr   <= '0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            ar_left    <= ar_left_nx;
            init_done  <= done_nx;
            ref_pend   <= pend_nx;
            ref_req    <= (pend_nx != 4'd0) && (state_nx == IDLE);
            ref_urgent <= (pend_nx >= 4'(URGENT_TH));
            cmd_own    <= own_nx;
            cmd_q      <= cmd_nx;
            cmd_addr   <= addr_nx;
            if (!init_done && done_nx)
                tmr <= TMR_W'(REF_INTERVAL - 1);
            else if (init_done)
                tmr <= (tmr == '0) ? TMR_W'(REF_INTERVAL - 1) : tmr - 1'b1;
        end
    end

endmodule

// File: tb/tb_sdram_init_refresh_ctrl.sv
// Directed bench for sdram_init_refresh_ctrl using the reduced timing set
// (PWRUP 16, TRP 2, TRFC 4, TMRD 2, INIT_AR 2, interval 20, urgent at 6).
module tb_sdram_init_refresh_ctrl;

    logic        sdram_clk = 1'b0;
    logic        sdram_rst = 1'b1;
    logic        ref_gnt   = 1'b0;
    logic        init_done, ref_req, ref_urgent, cmd_own;
    logic [3:0]  ref_pend;
    logic        cmd_cs_n, cmd_ras_n, cmd_cas_n, cmd_we_n;
    logic [12:0] cmd_addr;
    logic [1:0]  cmd_ba;

    sdram_init_refresh_ctrl #(
        .ADDR_W(13), .PWRUP_CYC(16), .TRP(2), .TRFC(4), .TMRD(2),
        .INIT_AR(2), .REF_INTERVAL(20), .URGENT_TH(6), .MODE_REG(13'h033)
    ) dut (
        .sdram_clk(sdram_clk), .sdram_rst(sdram_rst), .ref_gnt(ref_gnt),
        .init_done(init_done), .ref_req(ref_req), .ref_urgent(ref_urgent),
        .ref_pend(ref_pend), .cmd_own(cmd_own), .cmd_cs_n(cmd_cs_n),
        .cmd_ras_n(cmd_ras_n), .cmd_cas_n(cmd_cas_n), .cmd_we_n(cmd_we_n),
        .cmd_addr(cmd_addr), .cmd_ba(cmd_ba)
    );

    always #5 sdram_clk = ~sdram_clk;

    localparam logic [3:0] INH = 4'b1111, NOP = 4'b0111, PRE = 4'b0010,
                           AR  = 4'b0001, MRS = 4'b0000;

    typedef struct {
        int         e;
        bit         gnt;
        bit         own;
        logic [3:0] cmd;
        logic [12:0] addr;
        bit         done;
        int         pend;
        bit         req;
        bit         urg;
    } vec_t;

    vec_t tbl[$];
    int   checks   = 0;
    int   failures = 0;
    int   edge_n   = 0;
    wire [3:0] cmd = {cmd_cs_n, cmd_ras_n, cmd_cas_n, cmd_we_n};

    function automatic vec_t mk(int e, bit g, bit own, logic [3:0] c,
                                logic [12:0] a, bit d, int p, bit r, bit u);
        vec_t v;
        v.e = e; v.gnt = g; v.own = own; v.cmd = c; v.addr = a;
        v.done = d; v.pend = p; v.req = r; v.urg = u;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s edge=%0d got=%0h want=%0h", name, edge_n, act, exp);
        end
    endtask

    task automatic step();
        @(posedge sdram_clk);
        #1;
        edge_n++;
    endtask

    task automatic check_vec(vec_t v);
        chk("cmd_own", 32'(cmd_own), 32'(v.own));
        chk("init_done", 32'(init_done), 32'(v.done));
        chk("ref_pend", 32'(ref_pend), v.pend);
        chk("ref_req", 32'(ref_req), 32'(v.req));
        chk("ref_urgent", 32'(ref_urgent), 32'(v.urg));
        if (v.own) begin
            chk("cmd", 32'(cmd), 32'(v.cmd));
            chk("cmd_addr", 32'(cmd_addr), 32'(v.addr));
            chk("cmd_ba", 32'(cmd_ba), 32'd0);
        end
    endtask

    task automatic run_table(int lo, int hi);
        for (int i = lo; i <= hi; i++) begin
            while (edge_n < tbl[i].e) step();
            check_vec(tbl[i]);
            ref_gnt = tbl[i].gnt;
        end
    endtask

    localparam int INIT_END = 10;

    initial begin
        int p;
        bit tick, arx, idle;

        // init, with a grant held throughout to show it is ignored
        tbl.push_back(mk(1,  1, 1, NOP, 13'h000, 0, 0, 0, 0));
        tbl.push_back(mk(16, 1, 1, NOP, 13'h000, 0, 0, 0, 0));
        tbl.push_back(mk(17, 1, 1, PRE, 13'h400, 0, 0, 0, 0));
        tbl.push_back(mk(18, 1, 1, NOP, 13'h000, 0, 0, 0, 0));
        tbl.push_back(mk(19, 1, 1, AR,  13'h000, 0, 0, 0, 0));
        tbl.push_back(mk(20, 1, 1, NOP, 13'h000, 0, 0, 0, 0));
        tbl.push_back(mk(23, 1, 1, AR,  13'h000, 0, 0, 0, 0));
        tbl.push_back(mk(24, 1, 1, NOP, 13'h000, 0, 0, 0, 0));
        tbl.push_back(mk(27, 1, 1, MRS, 13'h033, 0, 0, 0, 0));
        tbl.push_back(mk(28, 1, 1, NOP, 13'h000, 0, 0, 0, 0));
        tbl.push_back(mk(29, 1, 0, NOP, 13'h000, 1, 0, 0, 0));
        // spurious grant in IDLE with nothing pending
        tbl.push_back(mk(30, 1, 0, NOP, 13'h000, 1, 0, 0, 0));
        tbl.push_back(mk(45, 0, 0, NOP, 13'h000, 1, 0, 0, 0));
        tbl.push_back(mk(48, 0, 0, NOP, 13'h000, 1, 0, 0, 0));
        // single refresh
        tbl.push_back(mk(49, 0, 0, NOP, 13'h000, 1, 1, 1, 0));
        tbl.push_back(mk(52, 1, 0, NOP, 13'h000, 1, 1, 1, 0));
        tbl.push_back(mk(53, 0, 1, PRE, 13'h400, 1, 1, 0, 0));
        tbl.push_back(mk(54, 0, 1, NOP, 13'h000, 1, 1, 0, 0));
        tbl.push_back(mk(55, 0, 1, AR,  13'h000, 1, 0, 0, 0));
        tbl.push_back(mk(58, 0, 1, NOP, 13'h000, 1, 0, 0, 0));
        tbl.push_back(mk(59, 0, 0, NOP, 13'h000, 1, 0, 0, 0));
        // tick/AR collision on edge 89
        tbl.push_back(mk(69, 0, 0, NOP, 13'h000, 1, 1, 1, 0));
        tbl.push_back(mk(86, 1, 0, NOP, 13'h000, 1, 1, 1, 0));
        tbl.push_back(mk(87, 0, 1, PRE, 13'h400, 1, 1, 0, 0));
        tbl.push_back(mk(89, 0, 1, AR,  13'h000, 1, 1, 0, 0));
        tbl.push_back(mk(92, 0, 1, NOP, 13'h000, 1, 1, 0, 0));
        tbl.push_back(mk(93, 0, 0, NOP, 13'h000, 1, 1, 1, 0));
        tbl.push_back(mk(94, 0, 0, NOP, 13'h000, 1, 1, 1, 0));
        // build up to 4 pending, then refresh down to 3
        tbl.push_back(mk(109, 0, 0, NOP, 13'h000, 1, 2, 1, 0));
        tbl.push_back(mk(129, 0, 0, NOP, 13'h000, 1, 3, 1, 0));
        tbl.push_back(mk(149, 0, 0, NOP, 13'h000, 1, 4, 1, 0));
        tbl.push_back(mk(150, 1, 0, NOP, 13'h000, 1, 4, 1, 0));
        tbl.push_back(mk(151, 0, 1, PRE, 13'h400, 1, 4, 0, 0));
        tbl.push_back(mk(153, 0, 1, AR,  13'h000, 1, 3, 0, 0));
        tbl.push_back(mk(154, 0, 1, NOP, 13'h000, 1, 3, 0, 0));

        // INHIBIT while reset is held
        ref_gnt = 1'b1;
        repeat (3) @(posedge sdram_clk);
        #1;
        check_vec(mk(0, 1, 1, INH, 13'h000, 0, 0, 0, 0));
        sdram_rst = 1'b0;
        edge_n = 0;

        run_table(0, tbl.size() - 1);

        // asynchronous reset in R_TRFC with 3 pending
        #2 sdram_rst = 1'b1;
        #1;
        check_vec(mk(0, 0, 1, INH, 13'h000, 0, 0, 0, 0));
        step();
        step();
        check_vec(mk(0, 0, 1, INH, 13'h000, 0, 0, 0, 0));
        sdram_rst = 1'b0;
        edge_n = 0;
        ref_gnt = 1'b1;
        run_table(0, INIT_END);
        ref_gnt = 1'b0;

        // saturation without grant
        for (int e = 30; e <= 229; e++) begin
            step();
            p = (e - 29) / 20;
            if (p > 8) p = 8;
            chk("sat_pend", 32'(ref_pend), p);
            chk("sat_urgent", 32'(ref_urgent), 32'(p >= 6));
            chk("sat_req", 32'(ref_req), 32'(p > 0));
            chk("sat_own", 32'(cmd_own), 32'd0);
        end
        ref_gnt = 1'b1;

        // drain with grant held: refreshes every 7 edges, ticks every 20
        p = 8;
        for (int e = 230; e <= 306; e++) begin
            step();
            tick = ((e - 29) % 20) == 0;
            arx  = (e >= 232) && (e <= 302) && (((e - 232) % 7) == 0);
            idle = ((e - 229) % 7) == 0;
            if (tick && !arx && p < 8) p++;
            else if (arx && !tick) p--;
            chk("drain_pend", 32'(ref_pend), p);
            chk("drain_urgent", 32'(ref_urgent), 32'(p >= 6));
            chk("drain_own", 32'(cmd_own), 32'(!idle));
            chk("drain_req", 32'(ref_req), 32'(idle && p > 0));
            if (arx) chk("drain_ar", 32'(cmd), 32'(AR));
        end
        ref_gnt = 1'b0;
        while (edge_n < 309) step();
        chk("post_tick_pend", 32'(ref_pend), 32'd1);
        chk("post_tick_req", 32'(ref_req), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
